// File: rtl/ctrl_mem_pkg.sv
// Shared constants and pointer-width helpers for the ULA result history.
package ctrl_mem_pkg;

  localparam int OP_NOP = 0;

  // Index width; a 1-entry memory still needs one address bit.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/banco_historico.sv
// DEPTH x WIDTH register file: one write port, two async read ports, sync clear.
// Writes land on the clock edge; reads are combinational; no backpressure.
module banco_historico #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_limpar,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr_a,
  input  logic [AW-1:0]    i_raddr_b,
  output logic [WIDTH-1:0] o_rdata_a,
  output logic [WIDTH-1:0] o_rdata_b
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_limpar) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/controle_memoria_historico.sv
// Circular history of the last DEPTH ULA results with step-back/forward recall; 1-cycle store latency.
// No backpressure. Define CTRL_MEM_EDGE_EN to store once per executar press instead of once per cycle.
module controle_memoria_historico
  import ctrl_mem_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int OP_W  = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [OP_W-1:0]           operacao,
  input  logic [WIDTH-1:0]          resultado_ula,
  input  logic                      executar,
  input  logic                      limpar,
  input  logic                      recuar,
  input  logic                      avancar,
  output logic                      carregar_memoria,
  output logic [WIDTH-1:0]          valor_memoria,
  output logic [WIDTH-1:0]          valor_historico,
  output logic [ptr_w(DEPTH)-1:0]   indice_historico,
  output logic [occ_w(DEPTH)-1:0]   ocupacao,
  output logic                      hist_cheio,
  output logic [WIDTH-1:0]          resultado_final
);

  localparam int AW = ptr_w(DEPTH);
  localparam int CW = occ_w(DEPTH);

  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_indice;
  logic [CW-1:0]    r_ocup;
  logic             w_exec_q;
  logic             w_vazio;
  logic [CW-1:0]    w_indice_ext;
  logic [AW-1:0]    w_rd_ult;
  logic [AW-1:0]    w_rd_hist;
  logic [WIDTH-1:0] w_dado_ult;
  logic [WIDTH-1:0] w_dado_hist;

`ifdef CTRL_MEM_EDGE_EN
  logic r_executar_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_executar_d <= 1'b0;
    else     r_executar_d <= executar;
  end

  assign w_exec_q = executar & ~r_executar_d;
`else
  assign w_exec_q = executar;
`endif

  assign carregar_memoria = w_exec_q & (operacao != OP_W'(OP_NOP)) & ~limpar;

  assign w_vazio      = (r_ocup == '0);
  assign w_indice_ext = CW'(r_indice);
  // DEPTH is a power of two, so pointer arithmetic wraps for free.
  assign w_rd_ult     = r_wr_ptr - AW'(1);
  assign w_rd_hist    = r_wr_ptr - AW'(1) - r_indice;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_ocup   <= '0;
      r_indice <= '0;
    end else if (limpar) begin
      r_wr_ptr <= '0;
      r_ocup   <= '0;
      r_indice <= '0;
    end else if (carregar_memoria) begin
      r_wr_ptr <= r_wr_ptr + AW'(1);
      if (r_ocup != CW'(DEPTH)) r_ocup <= r_ocup + CW'(1);
      r_indice <= '0;
    end else if (!w_vazio && (recuar ^ avancar)) begin
      if (recuar && (w_indice_ext < r_ocup - CW'(1))) r_indice <= r_indice + AW'(1);
      else if (avancar && (r_indice != '0))           r_indice <= r_indice - AW'(1);
    end
  end

  banco_historico #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_banco (
    .clk       (clk),
    .rst       (rst),
    .i_limpar  (limpar),
    .i_we      (carregar_memoria),
    .i_waddr   (r_wr_ptr),
    .i_wdata   (resultado_ula),
    .i_raddr_a (w_rd_ult),
    .i_raddr_b (w_rd_hist),
    .o_rdata_a (w_dado_ult),
    .o_rdata_b (w_dado_hist)
  );

  assign valor_memoria    = w_vazio ? '0 : w_dado_ult;
  assign valor_historico  = w_vazio ? '0 : w_dado_hist;
  assign resultado_final  = valor_historico;
  assign indice_historico = r_indice;
  assign ocupacao         = r_ocup;
  assign hist_cheio       = (r_ocup == CW'(DEPTH));

endmodule

// File: tb/tb_controle_memoria_historico.sv
// Directed bench for controle_memoria_historico (DEPTH=4, WIDTH=8).
module tb_controle_memoria_historico;

  logic       clk;
  logic       rst;
  logic [2:0] operacao;
  logic [7:0] resultado_ula;
  logic       executar;
  logic       limpar;
  logic       recuar;
  logic       avancar;
  logic       carregar_memoria;
  logic [7:0] valor_memoria;
  logic [7:0] valor_historico;
  logic [1:0] indice_historico;
  logic [2:0] ocupacao;
  logic       hist_cheio;
  logic [7:0] resultado_final;

  int checks;
  int failures;

  controle_memoria_historico #(.WIDTH(8), .DEPTH(4), .OP_W(3)) dut (
    .clk              (clk),
    .rst              (rst),
    .operacao         (operacao),
    .resultado_ula    (resultado_ula),
    .executar         (executar),
    .limpar           (limpar),
    .recuar           (recuar),
    .avancar          (avancar),
    .carregar_memoria (carregar_memoria),
    .valor_memoria    (valor_memoria),
    .valor_historico  (valor_historico),
    .indice_historico (indice_historico),
    .ocupacao         (ocupacao),
    .hist_cheio       (hist_cheio),
    .resultado_final  (resultado_final)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One store pulse followed by an idle cycle so edge mode sees a fresh press.
  task automatic do_store(input logic [7:0] val, input logic expect_strobe);
    operacao      = 3'b001;
    resultado_ula = val;
    executar      = 1'b1;
    #1;
    checks++;
    if (carregar_memoria !== expect_strobe) begin
      failures++;
      $display("FAIL store_strobe val=%h got=%b exp=%b", val, carregar_memoria, expect_strobe);
    end
    tick();
    executar = 1'b0;
    #1;
    checks++;
    if (carregar_memoria !== 1'b0) begin
      failures++;
      $display("FAIL store_strobe_drop val=%h got=%b exp=0", val, carregar_memoria);
    end
    tick();
  endtask

  task automatic pulse_recall(input logic rec, input logic ava);
    recuar  = rec;
    avancar = ava;
    tick();
    recuar  = 1'b0;
    avancar = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (valor_memoria !== 8'h00 || valor_historico !== 8'h00 || resultado_final !== 8'h00 ||
        ocupacao !== 3'd0 || indice_historico !== 2'd0 || hist_cheio !== 1'b0 ||
        carregar_memoria !== 1'b0) begin
      failures++;
      $display("FAIL reset_state mem=%h hist=%h fin=%h occ=%0d idx=%0d full=%b ld=%b exp all 0",
               valor_memoria, valor_historico, resultado_final, ocupacao, indice_historico,
               hist_cheio, carregar_memoria);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_store();
    do_store(8'h11, 1'b1);
    checks++;
    if (valor_memoria !== 8'h11 || ocupacao !== 3'd1) begin
      failures++;
      $display("FAIL store_first mem=%h occ=%0d exp mem=11 occ=1", valor_memoria, ocupacao);
    end
    do_store(8'h22, 1'b1);
    do_store(8'h33, 1'b1);
    checks++;
    if (valor_memoria !== 8'h33 || ocupacao !== 3'd3 || resultado_final !== 8'h33 ||
        hist_cheio !== 1'b0) begin
      failures++;
      $display("FAIL store_three mem=%h occ=%0d fin=%h full=%b exp mem=33 occ=3 fin=33 full=0",
               valor_memoria, ocupacao, resultado_final, hist_cheio);
    end
  endtask

  task automatic test_nop();
    operacao      = 3'b000;
    resultado_ula = 8'h99;
    executar      = 1'b1;
    #1;
    checks++;
    if (carregar_memoria !== 1'b0) begin
      failures++;
      $display("FAIL nop_strobe got=%b exp=0", carregar_memoria);
    end
    tick();
    executar = 1'b0;
    tick();
    checks++;
    if (valor_memoria !== 8'h33 || ocupacao !== 3'd3) begin
      failures++;
      $display("FAIL nop_history mem=%h occ=%0d exp mem=33 occ=3", valor_memoria, ocupacao);
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (valor_memoria !== 8'h00 || resultado_final !== 8'h00 || ocupacao !== 3'd0 ||
        hist_cheio !== 1'b0 || indice_historico !== 2'd0) begin
      failures++;
      $display("FAIL reset_mid mem=%h fin=%h occ=%0d full=%b idx=%0d exp all 0",
               valor_memoria, resultado_final, ocupacao, hist_cheio, indice_historico);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 5; i++) do_store(8'(i), 1'b1);
    checks++;
    if (ocupacao !== 3'd4 || hist_cheio !== 1'b1 || valor_memoria !== 8'h05) begin
      failures++;
      $display("FAIL overflow_full occ=%0d full=%b mem=%h exp occ=4 full=1 mem=05",
               ocupacao, hist_cheio, valor_memoria);
    end
    pulse_recall(1'b1, 1'b0);
    checks++;
    if (indice_historico !== 2'd1 || valor_historico !== 8'h04) begin
      failures++;
      $display("FAIL recall_one idx=%0d hist=%h exp idx=1 hist=04", indice_historico, valor_historico);
    end
    for (int i = 0; i < 4; i++) pulse_recall(1'b1, 1'b0);
    checks++;
    if (indice_historico !== 2'd3 || valor_historico !== 8'h02 || resultado_final !== 8'h02) begin
      failures++;
      $display("FAIL recall_saturate idx=%0d hist=%h fin=%h exp idx=3 hist=02 fin=02",
               indice_historico, valor_historico, resultado_final);
    end
    pulse_recall(1'b0, 1'b1);
    checks++;
    if (indice_historico !== 2'd2 || valor_historico !== 8'h03) begin
      failures++;
      $display("FAIL avancar_one idx=%0d hist=%h exp idx=2 hist=03", indice_historico, valor_historico);
    end
  endtask

  task automatic test_store_recall_clear();
    operacao      = 3'b001;
    resultado_ula = 8'h77;
    executar      = 1'b1;
    recuar        = 1'b1;
    tick();
    executar = 1'b0;
    recuar   = 1'b0;
    checks++;
    if (indice_historico !== 2'd0 || valor_historico !== 8'h77 || ocupacao !== 3'd4) begin
      failures++;
      $display("FAIL store_over_recall idx=%0d hist=%h occ=%0d exp idx=0 hist=77 occ=4",
               indice_historico, valor_historico, ocupacao);
    end
    tick();
    pulse_recall(1'b1, 1'b0);
    pulse_recall(1'b1, 1'b1);
    checks++;
    if (indice_historico !== 2'd1 || valor_historico !== 8'h05) begin
      failures++;
      $display("FAIL both_recall idx=%0d hist=%h exp idx=1 hist=05", indice_historico, valor_historico);
    end
    pulse_recall(1'b0, 1'b1);
    pulse_recall(1'b0, 1'b1);
    checks++;
    if (indice_historico !== 2'd0 || valor_historico !== 8'h77) begin
      failures++;
      $display("FAIL avancar_floor idx=%0d hist=%h exp idx=0 hist=77", indice_historico, valor_historico);
    end
    resultado_ula = 8'h88;
    executar      = 1'b1;
    limpar        = 1'b1;
    #1;
    checks++;
    if (carregar_memoria !== 1'b0) begin
      failures++;
      $display("FAIL clear_strobe got=%b exp=0", carregar_memoria);
    end
    tick();
    executar = 1'b0;
    limpar   = 1'b0;
    checks++;
    if (ocupacao !== 3'd0 || valor_memoria !== 8'h00 || valor_historico !== 8'h00 ||
        hist_cheio !== 1'b0 || indice_historico !== 2'd0) begin
      failures++;
      $display("FAIL clear_state occ=%0d mem=%h hist=%h full=%b idx=%0d exp all 0",
               ocupacao, valor_memoria, valor_historico, hist_cheio, indice_historico);
    end
    tick();
    pulse_recall(1'b1, 1'b0);
    checks++;
    if (indice_historico !== 2'd0) begin
      failures++;
      $display("FAIL empty_recall idx=%0d exp=0", indice_historico);
    end
  endtask

  task automatic test_exec_hold();
    logic [2:0] exp_occ;
    logic [7:0] exp_mem;
`ifdef CTRL_MEM_EDGE_EN
    exp_occ = 3'd1;
    exp_mem = 8'hA0;
`else
    exp_occ = 3'd4;
    exp_mem = 8'hA3;
`endif
    operacao = 3'b001;
    executar = 1'b1;
    for (int i = 0; i < 4; i++) begin
      resultado_ula = 8'hA0 + 8'(i);
      tick();
    end
    executar = 1'b0;
    tick();
    checks++;
    if (ocupacao !== exp_occ || valor_memoria !== exp_mem) begin
      failures++;
      $display("FAIL exec_hold occ=%0d mem=%h exp occ=%0d mem=%h",
               ocupacao, valor_memoria, exp_occ, exp_mem);
    end
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    operacao      = 3'b000;
    resultado_ula = 8'h00;
    executar      = 1'b0;
    limpar        = 1'b0;
    recuar        = 1'b0;
    avancar       = 1'b0;
    test_reset();
    test_store();
    test_nop();
    test_reset_mid();
    test_overflow();
    test_store_recall_clear();
    test_exec_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
